// File: rtl/softmax_stream_pkg.sv
// softmax_pkg: shared types and constants for the softmax_stream block.
//   state_t      : controller states (LOAD / DIV / OUT)
//   EXP_SH1/2    : shift amounts of the shift-add log2(e) scaling in the exp stage
//   clog2_min1() : index width helper that never returns zero
package softmax_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_DIV  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // y = x + x/2 - x/16 ~= x * log2(e)
  localparam int EXP_SH1 = 1;
  localparam int EXP_SH2 = 4;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_N     = 8;
  localparam int DEF_IDX_W = clog2_min1(DEF_N);

endpackage

// File: rtl/softmax_stream_if.sv
// softmax_stream_if: input and output beat handshakes of softmax_stream.
//   in_valid/in_ready/in_data           : signed QX.FRAC_W element stream in
//   out_valid/out_ready/out_data        : unsigned Q0.OUT_W probability out
//   out_idx/out_last                    : element index and last-of-frame flag
// Modports: slave = the softmax block, master = the source/sink driving it.
interface softmax_stream_if
  import softmax_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int IDX_W = DEF_IDX_W
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/softmax_stream_exp.sv
// softmax_exp_approx: combinational base-2 exponent approximation.
//   i_x : signed QX.FRAC_W input (positive values clamp to 0)
//   o_e : unsigned E ~= 2^FRAC_W * exp(min(x,0)), FRAC_W+1 bits
// The fractional part of y becomes a linear 1+f mantissa, the integer
// part a right shift; anything shifted past the word is zero.
module softmax_exp_approx
  import softmax_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 10
) (
  input  logic signed [IN_W-1:0] i_x,
  output logic [FRAC_W:0]        o_e
);
  localparam int E_W = FRAC_W + 1;
  localparam int Y_W = IN_W + 1;
  localparam int K_W = Y_W - FRAC_W;

  logic signed [IN_W-1:0] w_xn;
  logic signed [Y_W-1:0]  w_xe;
  logic signed [Y_W-1:0]  w_y;
  logic signed [K_W-1:0]  w_k;
  logic [K_W-1:0]         w_nk;
  logic [E_W-1:0]         w_m;

  assign w_xn = i_x[IN_W-1] ? i_x : '0;
  assign w_xe = {w_xn[IN_W-1], w_xn};
  // one extra bit covers the 1.4375x growth of the scaling
  assign w_y  = w_xe + (w_xe >>> EXP_SH1) - (w_xe >>> EXP_SH2);
  // slicing a two's-complement value gives floor division for k
  assign w_k  = w_y[Y_W-1:FRAC_W];
  assign w_nk = -w_k;
  assign w_m  = {1'b1, w_y[FRAC_W-1:0]};
  assign o_e  = (w_nk >= K_W'(E_W)) ? '0 : (w_m >> w_nk);
endmodule

// File: rtl/softmax_stream.sv
// softmax_stream: frame-based streaming softmax.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : softmax_stream_if.slave (input beats in, probabilities out)
//   busy       : high while dividing or presenting results
// LOAD collects N exp values and their sum; DIV runs a restoring divider
// E[idx]*2^OUT_W / den one bit per cycle; OUT presents each quotient.
module softmax_stream
  import softmax_pkg::*;
#(
  parameter int N      = 8,
  parameter int IN_W   = 16,
  parameter int FRAC_W = 10,
  parameter int OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  softmax_stream_if.slave  bus,
  output logic             busy
);
  localparam int E_W   = FRAC_W + 1;
  localparam int IDX_W = clog2_min1(N);
  localparam int D_W   = E_W + IDX_W;
  localparam int DC_W  = clog2_min1(OUT_W + 1);

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_cnt, r_idx;
  logic [D_W-1:0]     r_den;
  logic [E_W-1:0]     r_buf [N];
  logic [D_W:0]       r_rem;
  logic [OUT_W-1:0]   r_q;
  logic [DC_W-1:0]    r_dcnt;
  logic [OUT_W-1:0]   r_out;

  logic [E_W-1:0]     w_e;
  logic               w_acc, w_last_in, w_div_done, w_out_hs, w_idx_last;
  logic [D_W:0]       w_src;
  logic               w_ge;
  logic [D_W-1:0]     w_diff;
  logic [OUT_W:0]     w_q_nxt;

  function automatic logic [OUT_W-1:0] sat_q(input logic [OUT_W:0] q, input logic den_zero);
    if (den_zero)  return '0;
    if (q[OUT_W])  return '1;
    return q[OUT_W-1:0];
  endfunction

  softmax_exp_approx #(.IN_W(IN_W), .FRAC_W(FRAC_W)) u_exp (
    .i_x (bus.in_data),
    .o_e (w_e)
  );

  assign w_acc      = bus.in_valid && (r_state == S_LOAD);
  assign w_last_in  = w_acc && (r_cnt == IDX_W'(N - 1));
  assign w_div_done = (r_state == S_DIV) && (r_dcnt == DC_W'(OUT_W));
  assign w_out_hs   = (r_state == S_OUT) && bus.out_ready;
  assign w_idx_last = (r_idx == IDX_W'(N - 1));

  // first divider cycle takes the dividend straight from the buffer
  assign w_src   = (r_dcnt == '0) ? (D_W + 1)'(r_buf[r_idx]) : r_rem;
  assign w_ge    = (w_src >= {1'b0, r_den});
  assign w_diff  = w_ge ? D_W'(w_src - {1'b0, r_den}) : D_W'(w_src);
  assign w_q_nxt = {r_q, w_ge};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_last_in)  w_state_nxt = S_DIV;
      S_DIV:   if (w_div_done) w_state_nxt = S_OUT;
      S_OUT:   if (w_out_hs)   w_state_nxt = w_idx_last ? S_LOAD : S_DIV;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_buf[r_cnt] <= w_e;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_den  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_dcnt <= '0;
      r_out  <= '0;
    end else begin
      case (r_state)
        // ---- LOAD: accumulate buffer and denominator
        S_LOAD: if (w_acc) begin
          r_den <= r_den + D_W'(w_e);
          r_cnt <= w_last_in ? '0 : r_cnt + 1'b1;
          if (w_last_in) begin
            r_idx  <= '0;
            r_dcnt <= '0;
          end
        end
        // ---- DIV: one quotient bit per cycle
        S_DIV: begin
          r_rem <= {w_diff, 1'b0};
          r_q   <= w_q_nxt[OUT_W-1:0];
          if (w_div_done) begin
            r_out  <= sat_q(w_q_nxt, r_den == '0);
            r_dcnt <= '0;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        // ---- OUT: hold result until accepted
        S_OUT: if (w_out_hs) begin
          if (w_idx_last) begin
            r_idx <= '0;
            r_den <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_LOAD);
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.out_data  = r_out;
  assign bus.out_idx   = r_idx;
  assign bus.out_last  = (r_state == S_OUT) && w_idx_last;
  assign busy          = (r_state != S_LOAD);
endmodule

// File: doc/softmax_stream.md
SOFTMAX_STREAM -- requirements
Module: softmax_stream

Interface
REQ-001 SHALL have parameter N, default 8, elements per frame (2..64).
REQ-002 SHALL have parameter IN_W, default 16, signed input width.
REQ-003 SHALL have parameter FRAC_W, default 10, input fraction bits; E_W = FRAC_W+1.
REQ-004 SHALL have parameter OUT_W, default 16, output fraction bits (unsigned Q0.OUT_W).
REQ-005 SHALL have port clk, input, 1, sole clock; one clock, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, IN_W): input beat handshake and signed QX.FRAC_W element.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, OUT_W): output beat handshake and probability.
REQ-009 SHALL have ports out_idx (output, clog2(N)) and out_last (output, 1): element index 0..N-1, and a flag high on index N-1.
REQ-010 SHALL have port busy, output, 1, high whenever state is not LOAD.

Function
REQ-011 Exp approx per element: x' = min(x,0); y = x' + (x'>>>1) - (x'>>>4); k = floor(y/2^FRAC_W); f = y - k*2^FRAC_W; E = (2^FRAC_W + f) >> (-k), 0 if -k >= E_W.
REQ-012 States LOAD, DIV, OUT; reset state LOAD.
REQ-013 LOAD: in_ready=1; each beat with in_valid stores E in buffer slot cnt and adds it to den (width E_W+clog2(N)); cnt increments.
REQ-014 Beat accepted with cnt=N-1 -> DIV, idx=0, cnt=0.
REQ-015 DIV: restoring divider, one quotient bit per cycle, exactly OUT_W+1 cycles, computes q = floor(E[idx]*2^OUT_W / den).
REQ-016 q >= 2^OUT_W SHALL saturate to 2^OUT_W-1; den=0 SHALL give q=0.
REQ-017 DIV complete -> OUT; out_valid=1, out_data=q, out_idx=idx, out_last=(idx==N-1).
REQ-018 out_valid and out_data/out_idx/out_last SHALL be held stable until out_ready sampled high.
REQ-019 OUT with out_ready: idx<N-1 -> DIV with idx+1; idx=N-1 -> LOAD, den cleared.
REQ-020 Latency: out_valid rises OUT_W+2 cycles after the last input beat is accepted; each later element follows OUT_W+2 cycles after the prior handshake.
REQ-021 in_ready=0 in DIV and OUT; in_valid during those states SHALL be ignored.
REQ-022 out_valid=0 outside OUT.

Reset
REQ-023 rst_n low at a clock edge: state=LOAD, cnt=0, idx=0, den=0, divider cleared.
REQ-024 Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, in_ready=1 on the first cycle after release.
REQ-025 Reset mid-DIV/OUT SHALL discard the frame; buffer contents need not be cleared.

Structure
REQ-026 Package softmax_pkg SHALL hold state enum, clog2-derived widths, and the exp shift-add constants.
REQ-027 Sub-module softmax_exp_approx (combinational, REQ-011) SHALL be instantiated once on the input path.

Verification
REQ-028 N=8, all x=0 -> each E=1024, den=8192, out_data=8192 x8, out_last only on idx 7.
REQ-029 N=2, x={0,-1024} -> E={1024,400}, den=1424, out_data={47127,18408}.
REQ-030 N=8, x[0]=0, others -32768 -> out_data={65535,0,0,0,0,0,0,0}; all x=-32768 -> all 0.
REQ-031 x=+2000 -> treated as 0, E=1024.
REQ-032 Random out_ready backpressure -> outputs stable while stalled, no beat lost, in_ready=0 until frame drained.
REQ-033 rst_n low during DIV of idx 3 -> out_valid=0, busy=0 next cycle; next frame matches REQ-028.
